bs_gnrtr_n_rbtr: RTL and testbench

//  Shared-bus generator and round-robin arbiter for a multi-driver packet bus.

---
 rtl/bus_pkg.sv | 16 +
 rtl/bus_lane_arbiter.sv | 109 ++++++++++
 rtl/bs_gnrtr_n_rbtr.sv | 35 +++
 tb/tb_bs_gnrtr_n_rbtr.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared constants, FSM state type and header decode for the packet bus arbiter.
package bus_pkg;

    localparam int unsigned     ID_W      = 8;
    localparam logic [ID_W-1:0] BROADCAST = 8'hFF;
    localparam int unsigned     PKT_MAX   = 256;

    typedef enum logic [1:0] {ARB, POP, PUSH} arb_state_t;

    // Destination ID sits in the top ID_W bits of a packet that is sz bits wide.
    function automatic logic [ID_W-1:0] dest_of(input logic [PKT_MAX-1:0] pkt,
                                                input int unsigned        sz);
        return ID_W'(pkt >> (sz - ID_W));
    endfunction

endpackage

// File: rtl/bus_lane_arbiter.sv
// One bus lane: round-robin grant, single-cycle pop, then routed push of the latched packet.
module bus_lane_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned     drvrs     = 4,
    parameter int unsigned     pckg_sz   = 16,
    parameter logic [ID_W-1:0] broadcast = BROADCAST
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [drvrs-1:0]                  pndng,
    input  logic [drvrs-1:0][pckg_sz-1:0]     D_pop,
    output logic [drvrs-1:0]                  push,
    output logic [drvrs-1:0]                  pop,
    output logic [drvrs-1:0][pckg_sz-1:0]     D_push
);

    localparam int unsigned IDX_W = (drvrs > 1) ? $clog2(drvrs) : 1;

    arb_state_t               state_q, state_d;
    logic [IDX_W-1:0]         rr_q, rr_d;
    logic [IDX_W-1:0]         src_q, src_d;
    logic [pckg_sz-1:0]       pkt_q, pkt_d;
    logic [drvrs-1:0]         pop_q, pop_d;
    logic [drvrs-1:0]         push_q, push_d;
    logic [IDX_W-1:0]         grant;
    logic [ID_W-1:0]          dest;

    function automatic logic [IDX_W-1:0] first_pending(input logic [drvrs-1:0] req,
                                                       input logic [IDX_W-1:0]  start);
        logic [IDX_W-1:0] g;
        logic             found;
        int unsigned      idx;
        g     = start;
        found = 1'b0;
        for (int unsigned i = 0; i < drvrs; i++) begin
            idx = 32'(start) + i;
            if (idx >= drvrs) idx = idx - drvrs;
            if (!found && req[idx]) begin
                found = 1'b1;
                g     = IDX_W'(idx);
            end
        end
        return g;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB;
            rr_q    <= '0;
            src_q   <= '0;
            pkt_q   <= '0;
            pop_q   <= '0;
            push_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            src_q   <= src_d;
            pkt_q   <= pkt_d;
            pop_q   <= pop_d;
            push_q  <= push_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB:     if (|pndng) state_d = POP;
            POP:     state_d = PUSH;
            PUSH:    state_d = ARB;
            default: state_d = ARB;
        endcase
    end

    // Strobes are computed one state ahead so that pop/push come straight off flops.
    always_comb begin
        grant  = first_pending(pndng, rr_q);
        dest   = dest_of(PKT_MAX'(D_pop[src_q]), pckg_sz);
        rr_d   = rr_q;
        src_d  = src_q;
        pkt_d  = pkt_q;
        pop_d  = '0;
        push_d = '0;
        case (state_q)
            ARB: begin
                if (|pndng) begin
                    src_d        = grant;
                    pop_d[grant] = 1'b1;
                end
            end
            POP: begin
                pkt_d = D_pop[src_q];
                rr_d  = (src_q == IDX_W'(drvrs - 1)) ? '0 : src_q + 1'b1;
                if (dest == broadcast) begin
                    push_d        = '1;
                    push_d[src_q] = 1'b0;
                end else if (dest < ID_W'(drvrs)) begin
                    push_d[dest[IDX_W-1:0]] = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign pop    = pop_q;
    assign push   = push_q;
    assign D_push = {drvrs{pkt_q}};

endmodule

// File: rtl/bs_gnrtr_n_rbtr.sv
// Shared-bus generator and round-robin arbiter: one independent arbiter per bus lane.
module bs_gnrtr_n_rbtr
    import bus_pkg::*;
#(
    parameter int unsigned     bits      = 1,
    parameter int unsigned     drvrs     = 4,
    parameter int unsigned     pckg_sz   = 16,
    parameter logic [ID_W-1:0] broadcast = {8{1'b1}}
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [bits-1:0][drvrs-1:0]                 pndng,
    output logic [bits-1:0][drvrs-1:0]                 push,
    output logic [bits-1:0][drvrs-1:0]                 pop,
    input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]    D_pop,
    output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]    D_push
);

    for (genvar l = 0; l < bits; l++) begin : g_lane
        bus_lane_arbiter #(
            .drvrs     (drvrs),
            .pckg_sz   (pckg_sz),
            .broadcast (broadcast)
        ) u_lane (
            .clk    (clk),
            .reset  (reset),
            .pndng  (pndng[l]),
            .D_pop  (D_pop[l]),
            .push   (push[l]),
            .pop    (pop[l]),
            .D_push (D_push[l])
        );
    end

endmodule

// File: tb/tb_bs_gnrtr_n_rbtr.sv
// Directed bench: agent output FIFOs modelled as queues, outputs sampled on the falling edge.
module tb_bs_gnrtr_n_rbtr;

    localparam int unsigned BITS = 1;
    localparam int unsigned DRV  = 8;
    localparam int unsigned PSZ  = 16;

    logic                               clk = 1'b0;
    logic                               reset;
    logic [BITS-1:0][DRV-1:0]           pndng;
    logic [BITS-1:0][DRV-1:0]           push;
    logic [BITS-1:0][DRV-1:0]           pop;
    logic [BITS-1:0][DRV-1:0][PSZ-1:0]  D_pop;
    logic [BITS-1:0][DRV-1:0][PSZ-1:0]  D_push;

    logic [PSZ-1:0] q[DRV][$];
    logic [PSZ-1:0] tmp;
    logic           pop_seen;
    int unsigned    pop_idx;
    int unsigned    n_checks;
    int unsigned    n_errors;

    bs_gnrtr_n_rbtr #(
        .bits      (BITS),
        .drvrs     (DRV),
        .pckg_sz   (PSZ),
        .broadcast (8'hFF)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .pndng  (pndng),
        .push   (push),
        .pop    (pop),
        .D_pop  (D_pop),
        .D_push (D_push)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rep(input logic [PSZ-1:0] p);
        return {DRV{p}};
    endfunction

    task automatic refresh();
        for (int d = 0; d < DRV; d++) begin
            pndng[0][d] = (q[d].size() != 0);
            D_pop[0][d] = (q[d].size() != 0) ? q[d][0] : '0;
        end
    endtask

    // The agent FIFO drops its head on the edge that ends the pop cycle.
    task automatic tick();
        @(negedge clk);
        if (pop_seen) tmp = q[pop_idx].pop_front();
        pop_seen = 1'b0;
        for (int d = 0; d < DRV; d++) begin
            if (pop[0][d]) begin
                pop_seen = 1'b1;
                pop_idx  = d;
            end
        end
        refresh();
    endtask

    task automatic drain(input int budget);
        int n;
        int total;
        n = 0;
        total = 1;
        while (total != 0 && n < budget) begin
            tick();
            n++;
            total = 0;
            for (int d = 0; d < DRV; d++) total += q[d].size();
        end
        check("drain_left", 128'(total), 128'(0));
        tick();
        tick();
    endtask

    task automatic expect_out(input string tag, input logic [DRV-1:0] e_pop,
                              input logic [DRV-1:0] e_push);
        check({tag, "_pop"},  128'(pop[0]),  128'(e_pop));
        check({tag, "_push"}, 128'(push[0]), 128'(e_push));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        pop_seen = 1'b0;
        pop_idx  = 0;
        reset    = 1'b1;
        for (int d = 0; d < DRV; d++) q[d].push_back(16'h2000 | 16'(d));
        refresh();

        // Reset held with every agent pending.
        tick();
        expect_out("rst1", 8'h00, 8'h00);
        check("rst1_dpush", 128'(D_push[0]), 128'(0));
        tick();
        expect_out("rst2", 8'h00, 8'h00);
        check("rst2_dpush", 128'(D_push[0]), 128'(0));
        reset = 1'b0;
        tick();
        expect_out("rst_first", 8'h01, 8'h00);
        tick();
        expect_out("rst_inval", 8'h00, 8'h00);
        check("rst_inval_dpush", 128'(D_push[0]), rep(16'h2000));
        drain(100);

        // Unicast agent 2 -> agent 5.
        q[2].push_back(16'h05AB);
        refresh();
        tick();
        expect_out("uni_p", 8'b0000_0100, 8'h00);
        tick();
        expect_out("uni_q", 8'h00, 8'b0010_0000);
        check("uni_dpush", 128'(D_push[0]), rep(16'h05AB));
        tick();
        expect_out("uni_idle", 8'h00, 8'h00);
        check("uni_hold", 128'(D_push[0]), rep(16'h05AB));

        // Broadcast from agent 3.
        q[3].push_back(16'hFF12);
        refresh();
        tick();
        expect_out("bc_p", 8'b0000_1000, 8'h00);
        tick();
        expect_out("bc_q", 8'h00, 8'b1111_0111);
        check("bc_dpush", 128'(D_push[0]), rep(16'hFF12));
        tick();
        expect_out("bc_idle", 8'h00, 8'h00);

        // Invalid destination from agent 1: popped, never pushed.
        q[1].push_back(16'h0934);
        refresh();
        tick();
        expect_out("inv_p", 8'b0000_0010, 8'h00);
        tick();
        expect_out("inv_q", 8'h00, 8'h00);
        tick();
        expect_out("inv_idle", 8'h00, 8'h00);

        // Reset during pop of agent 5; pointer (2 before reset) must restart at 0.
        q[5].push_back(16'h0512);
        refresh();
        tick();
        expect_out("mid_p", 8'b0010_0000, 8'h00);
        reset = 1'b1;
        tick();
        expect_out("mid_rst", 8'h00, 8'h00);
        check("mid_dpush", 128'(D_push[0]), 128'(0));
        reset = 1'b0;
        q[6].push_back(16'h0161);
        q[0].push_back(16'h0300);
        refresh();
        tick();
        expect_out("mid_g0", 8'b0000_0001, 8'h00);
        tick();
        expect_out("mid_d0", 8'h00, 8'b0000_1000);
        check("mid_d0_data", 128'(D_push[0]), rep(16'h0300));
        tick();
        expect_out("mid_arb", 8'h00, 8'h00);
        tick();
        expect_out("mid_g6", 8'b0100_0000, 8'h00);
        tick();
        expect_out("mid_d6", 8'h00, 8'b0000_0010);
        check("mid_d6_data", 128'(D_push[0]), rep(16'h0161));
        tick();

        // Round robin: all agents pending, two packets each, unicast to neighbour.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int d = 0; d < DRV; d++) begin
            for (int k = 0; k < 2; k++) begin
                q[d].push_back({8'((d + 1) % DRV), 4'(k), 4'(d)});
            end
        end
        refresh();
        for (int j = 0; j < 2 * DRV; j++) begin
            int g;
            g = j % DRV;
            tick();
            expect_out("rr_pop", 8'(1 << g), 8'h00);
            tick();
            expect_out("rr_push", 8'h00, 8'(1 << ((g + 1) % DRV)));
            check("rr_data", 128'(D_push[0]), rep({8'((g + 1) % DRV), 4'(j / DRV), 4'(g)}));
            tick();
            expect_out("rr_gap", 8'h00, 8'h00);
        end
        tick();
        expect_out("rr_done", 8'h00, 8'h00);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
